fifo_wr_arbiter: RTL and testbench

- Round-robin, burst-locking write arbiter that shares one FIFO enqueue port among NUM_REQ producers.
- Sits directly in front of the distributed-RAM FIFO write side. It drives the FIFO's write-enable and write-data and observes the FIFO's full flag.
- Each producer uses a valid/ready/last handshake. A granted producer keeps the port until it completes a burst (last beat) or hits MAX_BURST beats.

---
 rtl/fifo_wr_arbiter.sv | 94 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO enqueue port among NUM_REQ producers.
// Beats transfer combinationally on the cycle they are granted; only arbitration state is registered.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_en,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_fifo_wren,
  output logic [DATA_W-1:0]         o_fifo_wrdata,
  input  logic                      i_fifo_full
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   beat_cnt;

  logic [PTR_W-1:0]   pick;
  logic               pick_found;
  logic [PTR_W:0]     scan_idx;
  logic [PTR_W-1:0]   g;
  logic               grant_act;
  logic               xfer;
  logic [CNT_W-1:0]   beat_nxt;
  logic               burst_end;
  logic [NUM_REQ-1:0] g_onehot;
  logic [PTR_W-1:0]   rr_after_g;

  // Rotating priority search starting at rr_ptr; scan_idx is one bit wider so the wrap never overflows
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      if (!pick_found && i_req_valid[scan_idx[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    g          = (state == LOCKED) ? owner : pick;
    grant_act  = rstn & i_en & ((state == LOCKED) | pick_found);
    xfer       = grant_act & ~i_fifo_full & i_req_valid[g];
    g_onehot   = NUM_REQ'(1) << g;
    beat_nxt   = beat_cnt + 1'b1;
    burst_end  = i_req_last[g] | (beat_nxt == CNT_W'(MAX_BURST));
    rr_after_g = (g == PTR_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
  end

  always_comb begin
    o_grant       = grant_act ? g_onehot : '0;
    o_req_ready   = xfer ? g_onehot : '0;
    o_fifo_wren   = xfer;
    o_fifo_wrdata = xfer ? i_req_data[g*DATA_W +: DATA_W] : '0;
  end

  // Arbitration state advances only on an accepted beat; stalls leave everything untouched
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (xfer) begin
      if (burst_end) begin
        state    <= IDLE;
        rr_ptr   <= rr_after_g;
        beat_cnt <= '0;
      end else begin
        state    <= LOCKED;
        owner    <= g;
        beat_cnt <= beat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked against a
// behavioural arbiter model (lock flag, owner, beat count, round-robin start index).
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            en;
  logic [N-1:0]    valid;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic            full;
  logic [N-1:0]    ready;
  logic [N-1:0]    grant;
  logic            wren;
  logic [DW-1:0]   wrdata;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_locked;
  int m_owner;
  int m_beats;
  int m_rr;
  int m_g;
  bit m_x;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .i_en(en), .i_req_valid(valid), .i_req_last(last),
    .i_req_data(data), .o_req_ready(ready), .o_grant(grant), .o_fifo_wren(wren),
    .o_fifo_wrdata(wrdata), .i_fifo_full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_beats = 0; m_rr = 0;
  endtask

  // Expected outputs from the arbitration rules, evaluated against the current inputs
  task automatic eval();
    logic [N-1:0]  eg, er;
    logic          ew;
    logic [DW-1:0] ed;
    bit has;
    #1;
    has = 0; m_g = 0; m_x = 0;
    if (m_locked) begin
      has = 1; m_g = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (!has && valid[(m_rr + k) % N]) begin has = 1; m_g = (m_rr + k) % N; end
    end
    eg = '0; er = '0; ew = 0; ed = '0;
    if (rstn && en && has) begin
      eg = N'(1) << m_g;
      if (!full && valid[m_g]) begin
        m_x = 1; ew = 1; er = eg; ed = data[m_g*DW +: DW];
      end
    end
    chk("grant", grant, eg);
    chk("ready", ready, er);
    chk("wren", wren, ew);
    chk("wrdata", wrdata, ed);
  endtask

  task automatic adv();
    if (!rstn) model_reset();
    else if (m_x) begin
      m_beats++;
      if (last[m_g] || m_beats == MB) begin
        m_locked = 0; m_beats = 0; m_rr = (m_g + 1) % N;
      end else begin
        m_locked = 1; m_owner = m_g;
      end
    end
    @(posedge clk);
    @(negedge clk);
    data = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rstn = 1'b0; eval(); adv(); rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp_tab [6];
    rstn = 1'b0; en = 1'b1; valid = '0; last = '0; full = 1'b0; data = {$urandom, $urandom};
    model_reset();
    @(negedge clk);

    // reset with traffic present: outputs must stay quiet
    valid = 4'b1111; last = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      eval(); chk("rst_grant", grant, 4'b0000); chk("rst_wren", wren, 1'b0); adv();
    end
    rstn = 1'b1;

    // single-beat round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      eval(); chk("rr_order", grant, N'(1) << (k % N)); chk("rr_wren", wren, 1'b1); adv();
    end

    // req1 3-beat burst with req2 pending
    valid = 4'b0110; last = 4'b0000;
    eval(); chk("b3_g1", grant, 4'b0010); adv();
    eval(); chk("b3_g2", grant, 4'b0010); adv();
    last = 4'b0010;
    eval(); chk("b3_g3", grant, 4'b0010); adv();
    last = 4'b0100;
    eval(); chk("b3_next", grant, 4'b0100); adv();

    // forced release after MAX_BURST beats, req3 slots in
    valid = 4'b1000; last = 4'b1000; eval(); adv();
    exp_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001};
    valid = 4'b1001; last = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      eval(); chk("maxb_grant", grant, exp_tab[k]); adv();
    end

    // FIFO full in the middle of req2's locked burst
    do_reset();
    valid = 4'b0100; last = 4'b0000;
    eval(); chk("full_b1", wren, 1'b1); adv();
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      eval(); chk("full_grant", grant, 4'b0100); chk("full_wren", wren, 1'b0);
      chk("full_ready", ready, 4'b0000); adv();
    end
    full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eval(); chk("full_resume", wren, 1'b1); adv();
    end
    eval(); adv();

    // owner drops valid while req0 waits
    do_reset();
    valid = 4'b0010; last = 4'b0000; eval(); adv();
    valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      eval(); chk("drop_grant", grant, 4'b0010); chk("drop_wren", wren, 1'b0); adv();
    end
    valid = 4'b0011; last = 4'b0010;
    eval(); chk("drop_last", grant, 4'b0010); chk("drop_lwren", wren, 1'b1); adv();
    eval(); chk("drop_req0", grant, 4'b0001); adv();

    // reset pulse mid-burst drops the lock, arbitration restarts at req0
    do_reset();
    valid = 4'b0010; last = 4'b0000; eval(); adv();
    rstn = 1'b0;
    eval(); chk("midrst_grant", grant, 4'b0000); chk("midrst_wren", wren, 1'b0); adv();
    rstn = 1'b1; valid = 4'b1111; last = 4'b1111;
    eval(); chk("midrst_restart", grant, 4'b0001); adv();

    // disabled arbiter
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      eval(); chk("dis_grant", grant, 4'b0000); chk("dis_wren", wren, 1'b0); adv();
    end
    en = 1'b1;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      valid = N'($urandom);
      last  = N'($urandom & $urandom);
      full  = ($urandom_range(0, 4) == 0);
      en    = ($urandom_range(0, 9) != 0);
      rstn  = ($urandom_range(0, 149) != 0);
      eval();
      chk("rnd_ready_inv", ready, grant & {N{wren}});
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
